div_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16-bit sequential divider among N requesters. It takes operand pairs from requesters and issues each accepted pair to the divider with a start pulse. It waits for the divider's done pulse, or for a timeout. It then returns quotient, remainder and status to the requester that owns the job. Divide-by-zero is trapped locally and never reaches the divider.

---
 rtl/div_arbiter.sv | 144 ++++++++++++++
 tb/tb_div_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one sequential divider among N requesters, with local divide-by-zero trap and timeout
module div_arbiter #(
  parameter int N       = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   a_in,
  input  logic [N*WIDTH-1:0]   b_in,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         rsp_valid,
  output logic [WIDTH-1:0]     rsp_q,
  output logic [WIDTH-1:0]     rsp_r,
  output logic                 rsp_dz,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 div_start,
  output logic [WIDTH-1:0]     div_a,
  output logic [WIDTH-1:0]     div_b,
  input  logic                 div_done,
  input  logic [WIDTH-1:0]     div_y,
  input  logic [WIDTH-1:0]     div_rem
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d, id_q, id_d, win;
  logic             win_ok;
  logic [WIDTH-1:0] a_lat_q, a_lat_d, b_lat_q, b_lat_d;
  logic [WIDTH-1:0] res_q_q, res_q_d, res_r_q, res_r_d;
  logic             dz_q, dz_d, err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
  logic             div_start_q, div_start_d, busy_q, busy_d;
  // descending scan leaves the first set bit at or after ptr as the winner
  always_comb begin
    win = ptr_q;
    win_ok = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % N]) begin
        win = IW'((int'(ptr_q) + k) % N);
        win_ok = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_lat_d = a_lat_q;
    b_lat_d = b_lat_q;
    res_q_d = res_q_q;
    res_r_d = res_r_q;
    dz_d    = dz_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (win_ok) begin
        state_d = ISSUE;
        id_d    = win;
        a_lat_d = a_in[int'(win)*WIDTH +: WIDTH];
        b_lat_d = b_in[int'(win)*WIDTH +: WIDTH];
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = (b_lat_q == '0) ? RESP : WAIT;
        if (b_lat_q == '0) begin
          res_q_d = '1;
          res_r_d = a_lat_q;
          dz_d    = 1'b1;
          err_d   = 1'b0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (div_done || cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = RESP;
          res_q_d = div_done ? div_y : '0;
          res_r_d = div_done ? div_rem : '0;
          dz_d    = 1'b0;
          err_d   = !div_done;
        end
      end
      RESP: begin
        state_d = IDLE;
        ptr_d   = (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // strobes are registered from the next state so they line up with the state they decode
  always_comb begin
    gnt_d       = (state_d == ISSUE) ? N'(1) << id_d : '0;
    rsp_valid_d = (state_d == RESP) ? N'(1) << id_d : '0;
    div_start_d = (state_d == ISSUE) && (b_lat_d != '0);
    busy_d      = (state_d != IDLE);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      a_lat_q     <= '0;
      b_lat_q     <= '0;
      res_q_q     <= '0;
      res_r_q     <= '0;
      dz_q        <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      div_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      a_lat_q     <= a_lat_d;
      b_lat_q     <= b_lat_d;
      res_q_q     <= res_q_d;
      res_r_q     <= res_r_d;
      dz_q        <= dz_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      div_start_q <= div_start_d;
      busy_q      <= busy_d;
    end
  end
  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_q     = res_q_q;
  assign rsp_r     = res_r_q;
  assign rsp_dz    = dz_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;
  assign div_start = div_start_q;
  assign div_a     = a_lat_q;
  assign div_b     = b_lat_q;
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed vector table plus hand-written round-robin, timeout and reset sequences
module tb_div_arbiter;
  localparam int N = 4, W = 16, TO = 40, LAT = 18;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] req = '0, gnt, rsp_valid;
  logic [N*W-1:0] a_in = '0, b_in = '0;
  logic [W-1:0] rsp_q, rsp_r, div_a, div_b, div_y = '0, div_rem = '0;
  logic rsp_dz, rsp_err, busy, div_start, div_done = 1'b0;
  logic div_en = 1'b1, force_done = 1'b0;
  logic [W-1:0] ma = '0, mb = 16'd1;
  int cd = 0;
  int errors = 0, checks = 0;

  typedef struct {
    int idx;
    logic [W-1:0] a, b, q, r;
    logic dz;
  } vec_t;

  div_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_r(rsp_r),
    .rsp_dz(rsp_dz), .rsp_err(rsp_err), .busy(busy), .div_start(div_start),
    .div_a(div_a), .div_b(div_b), .div_done(div_done), .div_y(div_y), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  // divider model with LAT cycles from start to done; can be muted or force-pulsed
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      cd = 0;
      div_done = 1'b0;
    end else begin
      div_done = force_done;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          div_done = 1'b1;
          div_y = ma / mb;
          div_rem = ma % mb;
        end
      end
      if (div_start && div_en) begin
        cd = LAT;
        ma = div_a;
        mb = div_b;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input logic eerr, input int elat, input logic alter);
    int n;
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    a_in[idx*W +: W] = a;
    b_in[idx*W +: W] = b;
    req = oh;
    tick();
    chk("gnt", 32'(gnt), 32'(oh));
    chk("div_start", 32'(div_start), 32'(b != '0));
    chk("busy", 32'(busy), 32'd1);
    if (b != '0) chk("div_b", 32'(div_b), 32'(b));
    req = '0;
    if (alter) begin
      a_in[idx*W +: W] = ~a;
      b_in[idx*W +: W] = 16'd1;
    end
    tick();
    n = 1;
    chk("gnt_pulse", 32'(gnt), 32'd0);
    while (rsp_valid == '0 && n < 60) begin
      tick();
      n++;
    end
    chk("latency", n, elat);
    chk("rsp_valid", 32'(rsp_valid), 32'(oh));
    chk("rsp_q", 32'(rsp_q), 32'(eq));
    chk("rsp_r", 32'(rsp_r), 32'(er));
    chk("rsp_dz", 32'(rsp_dz), 32'(edz));
    chk("rsp_err", 32'(rsp_err), 32'(eerr));
    if (alter) chk("div_a_held", 32'(div_a), 32'(a));
    tick();
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    logic [W-1:0] rqx[4];
    logic [W-1:0] rrx[4];
    int n, seen;
    vt[0] = '{0, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0};
    vt[1] = '{2, 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1};
    vt[2] = '{1, 16'd0, 16'd5, 16'd0, 16'd0, 1'b0};
    vt[3] = '{3, 16'd65535, 16'd255, 16'd257, 16'd0, 1'b0};
    vt[4] = '{1, 16'd65535, 16'd65535, 16'd1, 16'd0, 1'b0};
    vt[5] = '{0, 16'd12345, 16'd100, 16'd123, 16'd45, 1'b0};
    vt[6] = '{3, 16'd7, 16'd0, 16'hFFFF, 16'd7, 1'b1};
    rqx = '{16'd33, 16'd22, 16'd65535, 16'd0};
    rrx = '{16'd1, 16'd2, 16'd0, 16'd5};

    #12;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_flags", {div_start, busy, rsp_dz, rsp_err}, 32'd0);
    chk("rst_rsp", {rsp_q, rsp_r}, 32'd0);
    chk("rst_div_ab", {div_a, div_b}, 32'd0);
    rst = 1'b1;

    // round robin with every request held
    a_in = {16'd5, 16'd65535, 16'd200, 16'd100};
    b_in = {16'd10, 16'd1, 16'd9, 16'd3};
    req = '1;
    for (int j = 0; j < 5; j++) begin
      n = 0;
      while (gnt == '0 && n < 10) begin
        tick();
        n++;
      end
      chk("rr_gnt", 32'(gnt), 32'(N'(1) << (j % N)));
      n = 0;
      while (rsp_valid == '0 && n < 40) begin
        tick();
        n++;
      end
      chk("rr_rsp_valid", 32'(rsp_valid), 32'(N'(1) << (j % N)));
      chk("rr_q", 32'(rsp_q), 32'(rqx[j % N]));
      chk("rr_r", 32'(rsp_r), 32'(rrx[j % N]));
      tick();
    end
    req = '0;
    tick();

    for (int i = 0; i < 7; i++)
      run_job(vt[i].idx, vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz, 1'b0,
              (vt[i].b == '0) ? 1 : LAT + 1, 1'b0);

    // timeout, then a late done that must be ignored
    div_en = 1'b0;
    run_job(2, 16'd50, 16'd3, 16'd0, 16'd0, 1'b0, 1'b1, TO + 1, 1'b0);
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid != '0 || busy) seen++;
    end
    chk("late_done", seen, 0);
    div_en = 1'b1;

    run_job(1, 16'd900, 16'd4, 16'd225, 16'd0, 1'b0, 1'b0, LAT + 1, 1'b1);

    // reset during WAIT; ptr was 2, so after reset requester 1 must win over 3
    a_in[2*W +: W] = 16'd500;
    b_in[2*W +: W] = 16'd5;
    req = 4'b0100;
    tick();
    req = '0;
    repeat (5) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_strobes", {gnt, rsp_valid, div_start, busy}, 32'd0);
    chk("mid_rst_rsp", {rsp_q, rsp_r}, 32'd0);
    chk("mid_rst_div", {div_a, div_b, 14'd0, rsp_dz, rsp_err}, 32'd0);
    #2;
    rst = 1'b1;
    a_in[1*W +: W] = 16'd77;
    b_in[1*W +: W] = 16'd7;
    a_in[3*W +: W] = 16'd9;
    b_in[3*W +: W] = 16'd3;
    req = 4'b1010;
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'b0010);
    req = 4'b1000;
    n = 0;
    while (rsp_valid == '0 && n < 40) begin
      tick();
      n++;
    end
    chk("post_rst_rsp", 32'(rsp_valid), 32'b0010);
    chk("post_rst_q", {rsp_q, rsp_r}, {16'd11, 16'd0});
    n = 0;
    while (gnt == '0 && n < 10) begin
      tick();
      n++;
    end
    chk("post_rst_gnt3", 32'(gnt), 32'b1000);
    req = '0;
    n = 0;
    while (rsp_valid == '0 && n < 40) begin
      tick();
      n++;
    end
    chk("post_rst_rsp3", 32'(rsp_valid), 32'b1000);
    chk("post_rst_q3", {rsp_q, rsp_r}, {16'd3, 16'd0});
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
